// File: rtl/prog_loader_seq_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
// Holds the frame state encoding, default geometry and checksum width.
package prog_loader_seq_pkg;

    localparam int ADDR_W_DEF    = 7;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_WORDS_DEF = 128;
    localparam int CSUM_W        = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        RUN,
        ERR
    } state_t;

    // States in which a frame is being received from the host.
    function automatic logic in_frame(input state_t s);
        return (s == LEN) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_csum.sv
// Modulo-2**W running checksum with synchronous clear, add enable and a
// combinational test of whether sum plus the presented byte wraps to zero.
module prog_loader_csum
    import prog_loader_seq_pkg::*;
#(
    parameter int W = CSUM_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         add_en,
    input  logic [W-1:0] din,
    output logic         check_ok
);

    logic [W-1:0] sum_reg;
    logic [W-1:0] sum_next;

    // Truncated to W bits before the zero test so the carry is discarded.
    assign sum_next = sum_reg + din;
    assign check_ok = (sum_next == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
        end else if (clr) begin
            sum_reg <= '0;
        end else if (add_en) begin
            sum_reg <= sum_next;
        end
    end

endmodule

// File: rtl/prog_loader_seq.sv
// Boot sequencer: receives a length/payload/checksum frame from the host,
// writes the payload into instruction memory and releases the core on success.
module prog_loader_seq
    import prog_loader_seq_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int               LEFT_W  = ADDR_W + 1;
    localparam logic [DATA_W:0]  MAX_LEN = (DATA_W + 1)'(MAX_WORDS);

    state_t              state_reg;
    logic [LEFT_W-1:0]   left_reg;
    logic [ADDR_W-1:0]   addr_reg;

    logic accept;
    logic restart;
    logic len_bad;
    logic data_add;
    logic csum_ok;

    assign host_ready = in_frame(state_reg);
    assign accept     = host_valid && host_ready;
    // A running frame cannot be aborted by start, only by rst_n.
    assign restart    = start && !in_frame(state_reg);
    assign len_bad    = (host_data == '0) || ({1'b0, host_data} > MAX_LEN);
    assign data_add   = accept && (state_reg == DATA);

    prog_loader_csum #(
        .W (DATA_W)
    ) u_csum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (restart),
        .add_en   (data_add),
        .din      (host_data),
        .check_ok (csum_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            left_reg   <= '0;
            addr_reg   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst_n  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state_reg)
                IDLE, RUN, ERR: begin
                    if (restart) begin
                        state_reg <= LEN;
                        addr_reg  <= '0;
                        cpu_rst_n <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                LEN: begin
                    if (accept) begin
                        if (len_bad) begin
                            state_reg <= ERR;
                            busy      <= 1'b0;
                            err       <= 1'b1;
                        end else begin
                            state_reg <= DATA;
                            left_reg  <= LEFT_W'(host_data);
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= addr_reg;
                        imem_wdata <= host_data;
                        addr_reg   <= addr_reg + ADDR_W'(1);
                        left_reg   <= left_reg - LEFT_W'(1);
                        if (left_reg == LEFT_W'(1)) begin
                            state_reg <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (csum_ok) begin
                            state_reg <= RUN;
                            cpu_rst_n <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= ERR;
                            err       <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    cpu_rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader_seq.sv
// Randomised frame-level bench for prog_loader_seq with a behavioural
// model of the frame format, memory image and final loader status.
module tb_prog_loader_seq;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 8;
    localparam int MAX_WORDS = 128;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              host_valid;
    logic [DATA_W-1:0] host_data;
    logic              host_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    prog_loader_seq #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_ready (host_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    logic [7:0] mem_model [MAX_WORDS];
    logic [7:0] dut_mem   [MAX_WORDS];
    logic [7:0] frame_q   [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory image as seen through the write port.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && imem_we === 1'b1) begin
            dut_mem[imem_addr] = imem_wdata;
            wr_count++;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ready"}, host_ready, 0);
        check_val({tag, "_we"},    imem_we,    0);
        check_val({tag, "_addr"},  imem_addr,  0);
        check_val({tag, "_wdata"}, imem_wdata, 0);
        check_val({tag, "_cpu"},   cpu_rst_n,  0);
        check_val({tag, "_busy"},  busy,       0);
        check_val({tag, "_done"},  done,       0);
        check_val({tag, "_err"},   err,        0);
    endtask

    task automatic check_mem();
        int bad = 0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (dut_mem[i] !== mem_model[i]) bad++;
        end
        check_val("mem_image", bad, 0);
    endtask

    task automatic gap_cycle(input bit with_start);
        start      = with_start;
        host_valid = 1'b0;
        host_data  = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        check_val("gap_we", imem_we, 0);
        check_val("gap_busy", busy, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit exp_write, input int exp_addr);
        host_valid = 1'b1;
        host_data  = b;
        check_val("host_ready", host_ready, 1);
        @(negedge clk);
        host_valid = 1'b0;
        check_val("we", imem_we, exp_write);
        if (exp_write) begin
            check_val($sformatf("addr%0d", exp_addr), imem_addr, exp_addr);
            check_val($sformatf("wdata%0d", exp_addr), imem_wdata, b);
        end
    endtask

    // start with an optional simultaneous host byte, which must be ignored.
    task automatic pulse_start(input bit with_valid);
        start      = 1'b1;
        host_valid = with_valid;
        host_data  = 8'($urandom);
        @(negedge clk);
        start      = 1'b0;
        host_valid = 1'b0;
        check_val("st_busy",  busy,       1);
        check_val("st_ready", host_ready, 1);
        check_val("st_cpu",   cpu_rst_n,  0);
        check_val("st_done",  done,       0);
        check_val("st_err",   err,        0);
        check_val("st_we",    imem_we,    0);
    endtask

    task automatic build_frame(input int l, input bit good);
        int sum = 0;
        frame_q.delete();
        frame_q.push_back(8'(l));
        if (l >= 1 && l <= MAX_WORDS) begin
            for (int i = 0; i < l; i++) begin
                frame_q.push_back(8'($urandom));
                sum += int'(frame_q[i + 1]);
            end
            if (good) frame_q.push_back(8'((256 - (sum % 256)) % 256));
            else      frame_q.push_back(8'((256 - (sum % 256) + $urandom_range(1, 255)) % 256));
        end
    endtask

    task automatic run_frame(input int gap_pct, input bit inject_start);
        int  l;
        int  sum;
        int  wr0;
        bit  legal;
        bit  good;
        l     = int'(frame_q[0]);
        legal = (l >= 1) && (l <= MAX_WORDS);
        good  = 1'b0;
        wr0   = wr_count;
        pulse_start(1'($urandom_range(0, 1)));
        send_byte(frame_q[0], 1'b0, 0);
        if (legal) begin
            sum = 0;
            for (int i = 1; i <= l; i++) begin
                if ($urandom_range(0, 99) < gap_pct) gap_cycle(inject_start && ($urandom_range(0, 1) == 1));
                send_byte(frame_q[i], 1'b1, i - 1);
                mem_model[i - 1] = frame_q[i];
                sum += int'(frame_q[i]);
            end
            if ($urandom_range(0, 99) < gap_pct) gap_cycle(inject_start);
            send_byte(frame_q[l + 1], 1'b0, 0);
            good = ((sum + int'(frame_q[l + 1])) % 256) == 0;
        end
        check_val("end_done",  done,       good);
        check_val("end_err",   err,        !good);
        check_val("end_cpu",   cpu_rst_n,  good);
        check_val("end_busy",  busy,       0);
        check_val("end_ready", host_ready, 0);
        repeat (2) begin
            host_valid = 1'($urandom_range(0, 1));
            host_data  = 8'($urandom);
            @(negedge clk);
        end
        host_valid = 1'b0;
        check_val("hold_cpu",  cpu_rst_n, good);
        check_val("hold_err",  err,       !good);
        check_val("hold_we",   imem_we,   0);
        check_val("wr_count",  wr_count - wr0, legal ? l : 0);
        check_mem();
        $display("frame len=%0d legal=%0b good=%0b done=%0b err=%0b cpu_rst_n=%0b",
                 l, legal, good, done, err, cpu_rst_n);
    endtask

    initial begin
        for (int i = 0; i < MAX_WORDS; i++) begin
            mem_model[i] = 8'h00;
            dut_mem[i]   = 8'h00;
        end
        rst_n      = 1'b0;
        start      = 1'b0;
        host_valid = 1'b0;
        host_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_idle_outputs("idle");

        // Directed frames: good, bad checksum, illegal lengths.
        frame_q = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        run_frame(0, 1'b0);
        frame_q = '{8'h03, 8'h11, 8'h22, 8'h33, 8'hCE};
        run_frame(0, 1'b0);
        frame_q = '{8'h03, 8'h44, 8'h55, 8'h66, 8'hCD};
        run_frame(30, 1'b1);
        frame_q = '{8'h00};
        run_frame(0, 1'b0);
        frame_q = '{8'h81};
        run_frame(0, 1'b0);

        // Largest legal frame: 00..7F, checksum 40.
        frame_q.delete();
        frame_q.push_back(8'h80);
        for (int i = 0; i < MAX_WORDS; i++) frame_q.push_back(8'(i));
        frame_q.push_back(8'h40);
        run_frame(0, 1'b0);

        // Start from RUN with a short frame, then randomised frames.
        build_frame(2, 1'b1);
        run_frame(50, 1'b1);
        for (int n = 0; n < 20; n++) begin
            int pick = $urandom_range(0, 9);
            if (pick == 0)      build_frame($urandom_range(0, 1) == 1 ? 0 : $urandom_range(MAX_WORDS + 1, 255), 1'b1);
            else if (pick == 1) build_frame(MAX_WORDS, $urandom_range(0, 1) == 1);
            else                build_frame($urandom_range(1, 16), $urandom_range(0, 3) != 0);
            run_frame($urandom_range(0, 60), 1'b1);
        end

        // Asynchronous reset after the second payload byte.
        pulse_start(1'b0);
        send_byte(8'h05, 1'b0, 0);
        send_byte(8'hA1, 1'b1, 0);
        mem_model[0] = 8'hA1;
        send_byte(8'hB2, 1'b1, 1);
        mem_model[1] = 8'hB2;
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("postrst");
        check_mem();
        $display("frame len=5 aborted by rst_n after 2 payload bytes");

        // The loader must come back cleanly after the abort.
        build_frame(4, 1'b1);
        run_frame(20, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
